inv_chain_pipe: RTL and testbench
=================================

Name: inv_chain_pipe

Overview:
- Clocked, parametrised successor to the gate-level three-inverter chain.
- DEPTH registered stages, each WIDTH bits wide. Each stage optionally inverts, selected per stage by a mask.
- Carries a per-stage valid bit, supports stall and flush, and counts toggles seen on valid outputs.
- Used as a deterministic delay/inversion element for simulator regression benches and as a multi-cycle test load.

Parameters:
- WIDTH, 1, data bits per stage.
- DEPTH, 3, number of registered stages; legal range 1..64.
- INV_MASK, {DEPTH{1'b1}}, DEPTH-bit mask; bit k=1 means stage k inverts its input.
- CNT_W, 8, width of the toggle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; 0 stalls every stage.
- flush  input  1  synchronous clear of all valid bits and data.
- in_valid  input  1  qualifies in.
- in  input  WIDTH  data into stage 0.
- cnt_clr  input  1  synchronous clear of toggle_cnt.
- out  output  WIDTH  data of stage DEPTH-1.
- out_valid  output  1  valid bit of stage DEPTH-1.
- toggle_cnt  output  CNT_W  number of output changes between consecutive valid outputs.

Behaviour:
- Registers:
  - Per stage k: d[k] (WIDTH bits) and v[k].
  - last_out (WIDTH bits) and have_last (1 bit), used for toggle counting.
  - cnt (CNT_W bits).
- Outputs: out=d[DEPTH-1], out_valid=v[DEPTH-1], toggle_cnt=cnt. All are direct register outputs with no combinational path from the inputs.
- Reset: rst=1 at a clock edge forces all d, v, last_out, have_last and cnt to 0. out=0, out_valid=0, toggle_cnt=0 from the following cycle. rst overrides every other input, including when asserted mid-stream.
- Priority per edge: rst > flush > en.
- flush=1 (rst=0):
  - All d[k]<=0 and v[k]<=0. The word presented on in that cycle is dropped.
  - have_last<=0.
  - cnt is unaffected unless cnt_clr is also asserted.
- en=1, flush=0:
  - d[0] <= in ^ {WIDTH{INV_MASK[0]}}, v[0] <= in_valid.
  - For k>=1: d[k] <= d[k-1] ^ {WIDTH{INV_MASK[k]}}, v[k] <= v[k-1].
  - Invalid (bubble) words shift and invert like valid ones.
- en=0, flush=0: all d and v hold.
- Latency and polarity:
  - With en held high, in at edge t appears on out after edge t+DEPTH-1, i.e. DEPTH cycles after in is presented.
  - Net polarity is the parity of popcount(INV_MASK). Default DEPTH=3, all-ones mask gives out = ~in.
- Toggle counting, evaluated at each edge where the stage-(DEPTH-1) register loads a word with v=1 (en=1, flush=0, v[DEPTH-2] or in_valid when DEPTH=1):
  - If have_last=1 and the new word != last_out, this is a count event.
  - In all cases last_out <= new word and have_last <= 1.
- cnt behaviour:
  - A count event increments cnt by 1, saturating at 2^CNT_W-1. It never wraps.
  - cnt_clr=1 sets cnt<=0. If a count event coincides with cnt_clr, the clear wins (cnt=0) but last_out and have_last still update.
  - cnt_clr does not affect the pipeline.
- DEPTH=1: the single stage is both input and output stage; all rules above apply unchanged.

Test Plan:
- Basic chain (WIDTH=1, DEPTH=3, default mask, en=1): rst then in_valid=1 with in = 0, 1, 0, 1 on consecutive cycles -> out = 1, 0, 1, 0 starting 3 cycles later with out_valid=1, and toggle_cnt = 3.
- Mixed mask (DEPTH=4, INV_MASK=4'b0101, WIDTH=8): in=8'hA5 -> out=8'hA5 after 4 cycles, since even parity means no net inversion. With INV_MASK=4'b0111 the same input gives out=8'h5A.
- Stall: stream 3 valid words, drop en for 5 cycles mid-stream -> out and out_valid are frozen during the stall, and the stream resumes in order with total latency DEPTH + 5.
- Flush and reset mid-operation:
  - Pipeline full of valid words, flush=1 for one cycle -> out_valid=0 and out=0 the next cycle. The next valid word compared against last_out does not increment toggle_cnt.
  - rst=1 with en=1 -> all outputs 0.
- Saturation and clear (CNT_W=2): 5 alternating valid words -> toggle_cnt goes 1, 2, 3, 3 and holds at 3. cnt_clr asserted in the same cycle as a toggle -> toggle_cnt=0, and the next toggle gives 1.
- Bubbles: alternate in_valid = 1, 0, 1 with in = 1, 1, 0 -> out_valid = 1, 0, 1 after DEPTH cycles. The bubble word does not update last_out, so toggle_cnt increments by exactly 1.

Source files
------------

// File: rtl/inv_chain_pipe.sv
// Parametrised registered inversion chain with per-stage valid, stall/flush,
// and a saturating count of value changes between consecutive valid outputs.
module inv_chain_pipe #(
  parameter int unsigned      WIDTH    = 1,
  parameter int unsigned      DEPTH    = 3,
  parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b1}},
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] last_out;
  logic             have_last;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] stage_in [DEPTH];
  logic [DEPTH-1:0] stage_vin;
  logic [WIDTH-1:0] new_word;
  logic             new_vld;
  logic             count_event;

  // Input seen by each stage: the port for stage 0, the previous register otherwise.
  always_comb begin
    stage_in[0]  = in;
    stage_vin[0] = in_valid;
    for (int k = 1; k < int'(DEPTH); k++) begin
      stage_in[k]  = d[k-1];
      stage_vin[k] = v[k-1];
    end
  end

  // Word about to be loaded into the output stage and whether it counts as a toggle.
  always_comb begin
    new_word    = stage_in[DEPTH-1] ^ {WIDTH{INV_MASK[DEPTH-1]}};
    new_vld     = stage_vin[DEPTH-1];
    count_event = en && !flush && new_vld && have_last && (new_word != last_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) d[k] <= '0;
      v         <= '0;
      last_out  <= '0;
      have_last <= 1'b0;
      cnt       <= '0;
    end else begin
      if (flush) begin
        for (int k = 0; k < int'(DEPTH); k++) d[k] <= '0;
        v         <= '0;
        have_last <= 1'b0;
      end else if (en) begin
        for (int k = 0; k < int'(DEPTH); k++) d[k] <= stage_in[k] ^ {WIDTH{INV_MASK[k]}};
        v <= stage_vin;
        if (new_vld) begin
          last_out  <= new_word;
          have_last <= 1'b1;
        end
      end
      // Clear beats a coincident count event; counter saturates instead of wrapping.
      if (cnt_clr) begin
        cnt <= '0;
      end else if (count_event && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign out        = d[DEPTH-1];
  assign out_valid  = v[DEPTH-1];
  assign toggle_cnt = cnt;

endmodule

// File: tb/tb_inv_chain_pipe.sv
// Randomized bench for inv_chain_pipe: three configurations share one stimulus
// stream and are checked against a word-level reference model.
module tb_inv_chain_pipe;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic [0:0] o0;
  logic [7:0] o1, o2;
  logic       ov0, ov1, ov2;
  logic [7:0] c0;
  logic [1:0] c1;
  logic [2:0] c2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inv_chain_pipe u0 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in(din[0:0]), .cnt_clr(cnt_clr), .out(o0), .out_valid(ov0), .toggle_cnt(c0)
  );

  inv_chain_pipe #(.WIDTH(8), .DEPTH(4), .INV_MASK(4'b0101), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in(din), .cnt_clr(cnt_clr), .out(o1), .out_valid(ov1), .toggle_cnt(c1)
  );

  inv_chain_pipe #(.WIDTH(8), .DEPTH(1), .INV_MASK(1'b1), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in(din), .cnt_clr(cnt_clr), .out(o2), .out_valid(ov2), .toggle_cnt(c2)
  );

  // Per-configuration parameters as seen by the model.
  int          dep  [NI] = '{3, 4, 1};
  logic [63:0] msk  [NI] = '{64'h7, 64'h5, 64'h1};
  logic [7:0]  wm   [NI] = '{8'h01, 8'hFF, 8'hFF};
  int          cmax [NI] = '{255, 3, 7};

  // Words in flight: raw value, valid, and the first stage that still applies its inversion.
  logic [7:0] mval [NI][64];
  logic       mvld [NI][64];
  int         mst  [NI][64];
  logic [7:0] mlast [NI];
  logic       mhave [NI];
  int         mcnt  [NI];

  function automatic logic [7:0] word_at(int i, int pos);
    logic [7:0] w;
    w = mval[i][pos];
    for (int k = mst[i][pos]; k <= pos; k++)
      if (msk[i][k]) w = w ^ wm[i];
    return w;
  endfunction

  task automatic model_clear(int i);
    for (int p = 0; p < dep[i]; p++) begin
      mval[i][p] = 8'h00;
      mvld[i][p] = 1'b0;
      mst[i][p]  = p + 1;
    end
    mhave[i] = 1'b0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      bit evt;
      logic [7:0] w;
      evt = 1'b0;
      if (rst) begin
        model_clear(i);
        mlast[i] = 8'h00;
        mcnt[i]  = 0;
      end else begin
        if (flush) begin
          model_clear(i);
        end else if (en) begin
          for (int p = dep[i] - 1; p > 0; p--) begin
            mval[i][p] = mval[i][p-1];
            mvld[i][p] = mvld[i][p-1];
            mst[i][p]  = mst[i][p-1];
          end
          mval[i][0] = din & wm[i];
          mvld[i][0] = in_valid;
          mst[i][0]  = 0;
          if (mvld[i][dep[i]-1]) begin
            w = word_at(i, dep[i] - 1);
            if (mhave[i] && (w != mlast[i])) evt = 1'b1;
            mlast[i] = w;
            mhave[i] = 1'b1;
          end
        end
        if (cnt_clr) mcnt[i] = 0;
        else if (evt && (mcnt[i] < cmax[i])) mcnt[i] = mcnt[i] + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] go [NI];
    logic [31:0] gv [NI];
    logic [31:0] gc [NI];
    go = '{32'(o0), 32'(o1), 32'(o2)};
    gv = '{32'(ov0), 32'(ov1), 32'(ov2)};
    gc = '{32'(c0), 32'(c1), 32'(c2)};
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.out", i), go[i], 32'(word_at(i, dep[i] - 1)));
      check($sformatf("u%0d.out_valid", i), gv[i], 32'(mvld[i][dep[i]-1]));
      check($sformatf("u%0d.toggle_cnt", i), gc[i], 32'(mcnt[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] seq [4];
    seq = '{8'h00, 8'h01, 8'h00, 8'h01};

    rst = 1'b1;
    cycle();
    check("reset_cnt", 32'(c0), 32'd0);
    check("reset_valid", 32'(ov1), 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Alternating 0/1 stream: three value changes on the default chain.
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      din = seq[j];
      cycle();
    end
    in_valid = 1'b0;
    din = 8'h00;
    repeat (5) cycle();
    check("basic_toggles", 32'(c0), 32'd3);

    // Even-parity mask leaves the word unchanged after four stages.
    in_valid = 1'b1;
    din = 8'hA5;
    cycle();
    in_valid = 1'b0;
    din = 8'h00;
    repeat (3) cycle();
    check("mask0101_out", 32'(o1), 32'hA5);
    check("mask0101_valid", 32'(ov1), 32'd1);

    // Flush with a full pipeline clears outputs on the next cycle.
    in_valid = 1'b1;
    repeat (4) begin
      din = 8'($urandom);
      cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_out", 32'(o1), 32'd0);
    check("flush_valid", 32'(ov0), 32'd0);

    // Randomized traffic with stalls, flushes, resets and counter clears.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 9) < 8);
      in_valid = ($urandom_range(0, 9) < 7);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      din      = 8'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
